jtag_scan_sequencer: RTL
========================

# jtag_scan_sequencer

Hardware JTAG master that drives `tck`/`tms`/`tdi` into the on-chip JTAG icetap and samples `tdo`. It turns single-transaction commands into complete TAP state-machine walks: TAP reset, IR scan, DR scan, and run-test-idle padding. Typical commands are selecting `IDCODE`/`SCAN_N`/`EXTEST` and scanning GPIO config or data. It sits between a local command source (CPU/UART bridge) and the TAP, so firmware can drive the TAP without bit-banging.

## Interface
- `IR_LENGTH`, 4: instruction register length; IR scans always shift exactly this many bits.
- `MAX_DR_LEN`, 64: maximum DR scan length; width of `cmd_data`/`rsp_data`.
- `TCK_DIV`, 2: `clk` cycles per `tck` half-period, ≥1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `trst_` input 1: reset, asynchronous, active-high; clock `clk`.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: sequencer idle, can accept a command.
- `cmd_op` input 2: 0=TAP_RESET, 1=SCAN_IR, 2=SCAN_DR, 3=IDLE.
- `cmd_len` input 7: DR bit count (SCAN_DR) or `tck` count (IDLE); ignored otherwise.
- `cmd_data` input MAX_DR_LEN: TDI bits, LSB shifted first.
- `rsp_valid` output 1: one-cycle completion pulse; no backpressure.
- `rsp_err` output 1: command rejected; valid with `rsp_valid`.
- `rsp_data` output MAX_DR_LEN: captured TDO, bit i = i-th shifted bit; unused MSBs 0.
- `tck`, `tms`, `tdi` output 1: JTAG drive.
- `tdo` input 1: JTAG return; `tdo_oe` is not needed.

## Operation
- FSM states: IDLE, PREAMBLE, SHIFT, POSTAMBLE, RESP.
- Handshake: a command is accepted when `cmd_valid && cmd_ready`. `cmd_op`/`cmd_len`/`cmd_data` are latched on acceptance.
- `cmd_ready` is 1 only in IDLE.
- Internal flag `tap_known` is cleared by reset and set on TAP_RESET completion. SCAN_IR, SCAN_DR and IDLE require `tap_known`; all of them start and end in Run-Test/Idle.
- TAP_RESET: 6 `tck` pulses with TMS = 1,1,1,1,1,0 and TDI=0.
- SCAN_DR TMS sequence: 1,0,0 (Select-DR, Capture-DR, Shift-DR), then `cmd_len` shift bits with TMS=0 except the last bit, which has TMS=1. Postamble is 1,0 (Update-DR, RTI). Total pulses: `cmd_len`+5.
- SCAN_IR TMS sequence: 1,1,0,0, then IR_LENGTH shift bits (last bit TMS=1), then 1,0. Total pulses: IR_LENGTH+6.
- IDLE: `cmd_len` pulses, TMS=0, TDI=0. `cmd_len`=0 completes without any `tck` and without error.
- TDI is 0 outside shift bits. TDO is recorded only during shift bits.
- Errors: any of the following gives no `tck` activity and a `rsp_err`=1 pulse, with `rsp_data`=0:
  - SCAN_DR with `cmd_len`=0 or `cmd_len`>MAX_DR_LEN;
  - SCAN_IR, SCAN_DR or IDLE while `!tap_known`.
- Reset mid-command:
  - outputs go to their reset values immediately;
  - the command is dropped with no response;
  - `tap_known` is cleared.

## Timing
- Reset values: `tck`=0, `tms`=1, `tdi`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0. FSM goes to IDLE, so `cmd_ready`=1.
- Let acceptance be cycle k. Pulse 0 `tms`/`tdi` are valid from k+1.
- Pulse n:
  - `tck` rises at k+1+2n·TCK_DIV+TCK_DIV;
  - `tdo` is sampled in that same cycle;
  - `tck` falls at k+1+(2n+2)·TCK_DIV;
  - the next `tms`/`tdi` update in the same cycle `tck` falls.
- For N pulses:
  - `rsp_valid` is 1 at cycle k+1+2N·TCK_DIV, with `tck` low;
  - `cmd_ready` returns at the following cycle.
- Error and zero-length IDLE responses: `rsp_valid` at k+1; `cmd_ready` at k+2.
- `rsp_data`/`rsp_err` hold their value until the next response.
- `tms` idles at 0 after TAP_RESET. It returns to 1 only via reset.

## Configuration
- Macro: `JTAG_SCAN_SEQUENCER_CAPTURE_EN`.
- Defined: TDO is shifted into `rsp_data` as specified above.
- Undefined: the capture register is removed, and `rsp_data` is constant 0. Sequencing, timing and `rsp_valid`/`rsp_err` are unchanged.

## Test plan
- Run SCAN_DR before any TAP_RESET -> `rsp_err`=1 at k+1, `tck` stays 0.
- Run TAP_RESET with TCK_DIV=2 -> 6 `tck` pulses with period 4 `clk` and TMS 111110. `rsp_valid` at k+25, `rsp_err`=0.
- Run SCAN_DR with `cmd_len`=32 against the jtag_icetap TAP model (default IR = IDCODE) -> 37 pulses. `rsp_data[31:0]` equals the TAP IDCODE, and `rsp_data[31:0][0]`=1.
- Run SCAN_IR with `cmd_data`=4'ha -> TMS 1100 0001 10, TDI on shift bits 0,1,0,1. `rsp_data[3:0]` equals the TAP IR capture pattern (`[1:0]`=01).
- Select SCAN_N, scan DR 1'b0, select EXTEST, scan 4'b1111, then scan DR 4'b0000 -> the second DR scan returns `rsp_data[3:0]`=4'b1111.
- Assert reset mid-SCAN_DR, then send SCAN_DR -> no `rsp_valid` for the aborted command, outputs at reset values, and the next SCAN_DR gets `rsp_err`=1. Also: `cmd_len`=65 gets `rsp_err`=1.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_sequencer
// Turns single commands into complete TAP walks (reset, IR/DR scan, RTI pad).
// Optional TDO capture into rsp_data: define JTAG_SCAN_SEQUENCER_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
module jtag_scan_sequencer #(
  parameter int IR_LENGTH  = 4,
  parameter int MAX_DR_LEN = 64,
  parameter int TCK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  trst_,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [6:0]            cmd_len,
  input  logic [MAX_DR_LEN-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [MAX_DR_LEN-1:0] rsp_data,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo
);

  localparam logic [1:0] c_op_tap_reset = 2'd0;
  localparam logic [1:0] c_op_scan_ir   = 2'd1;
  localparam logic [1:0] c_op_scan_dr   = 2'd2;
  localparam logic [1:0] c_op_idle      = 2'd3;

  localparam int                 c_div_w   = $clog2(2 * TCK_DIV);
  localparam logic [c_div_w-1:0] c_rise_at = c_div_w'(TCK_DIV - 1);
  localparam logic [c_div_w-1:0] c_samp_at = c_div_w'(TCK_DIV);
  localparam logic [c_div_w-1:0] c_end_at  = c_div_w'(2 * TCK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREAMBLE  = 3'd1,
    S_SHIFT     = 3'd2,
    S_POSTAMBLE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_op;
  logic [6:0]            r_len;
  logic [6:0]            r_cnt;
  logic [5:0]            r_pre;
  logic [MAX_DR_LEN-1:0] r_sh;
  logic [c_div_w-1:0]    r_div;
  logic                  r_tck, r_tms, r_tdi;
  logic                  r_tap_known;
  logic                  r_rsp_err;

  logic                  w_active, w_pulse_end, w_last, w_accept;
  logic                  w_err, w_no_pulse, w_is_scan;
  logic [5:0]            w_pre_tms;
  logic [6:0]            w_pre_cnt;
  logic [6:0]            w_shift_len;

  always_comb begin
    w_active    = (r_state == S_PREAMBLE) || (r_state == S_SHIFT) || (r_state == S_POSTAMBLE);
    w_pulse_end = w_active && (r_div == c_end_at);
    w_last      = (r_cnt == 7'd1);
    w_accept    = (r_state == S_IDLE) && cmd_valid;
    w_err       = ((cmd_op != c_op_tap_reset) && !r_tap_known) ||
                  ((cmd_op == c_op_scan_dr) && ((cmd_len == 7'd0) || (cmd_len > 7'(MAX_DR_LEN))));
    w_no_pulse  = w_err || ((cmd_op == c_op_idle) && (cmd_len == 7'd0));
    w_is_scan   = (r_op == c_op_scan_ir) || (r_op == c_op_scan_dr);
    w_shift_len = (r_op == c_op_scan_ir) ? 7'(IR_LENGTH) : r_len;

    // Preamble TMS patterns are consumed LSB first
    w_pre_tms = 6'b000000;
    w_pre_cnt = cmd_len;
    case (cmd_op)
      c_op_tap_reset: begin w_pre_tms = 6'b011111; w_pre_cnt = 7'd6; end
      c_op_scan_ir:   begin w_pre_tms = 6'b000011; w_pre_cnt = 7'd4; end
      c_op_scan_dr:   begin w_pre_tms = 6'b000001; w_pre_cnt = 7'd3; end
      default:        ;
    endcase

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (cmd_valid) w_state_nxt = w_no_pulse ? S_RESP : S_PREAMBLE;
      S_PREAMBLE:  if (w_pulse_end && w_last) w_state_nxt = w_is_scan ? S_SHIFT : S_RESP;
      S_SHIFT:     if (w_pulse_end && w_last) w_state_nxt = S_POSTAMBLE;
      S_POSTAMBLE: if (w_pulse_end && w_last) w_state_nxt = S_RESP;
      S_RESP:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase

    cmd_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk or posedge trst_) begin
    if (trst_) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge trst_) begin
    if (trst_) begin
      r_op        <= 2'd0;
      r_len       <= 7'd0;
      r_cnt       <= 7'd0;
      r_pre       <= 6'd0;
      r_sh        <= '0;
      r_div       <= '0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_tap_known <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_active) r_div <= w_pulse_end ? '0 : r_div + 1'b1;
      if (w_active && (r_div == c_rise_at)) r_tck <= 1'b1;
      if (w_pulse_end) r_tck <= 1'b0;

      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= cmd_op;
          r_len <= cmd_len;
          r_sh  <= cmd_data;
          r_div <= '0;
          if (w_no_pulse) begin
            r_rsp_err <= w_err;
          end else begin
            r_tms <= w_pre_tms[0];
            r_pre <= {1'b0, w_pre_tms[5:1]};
            r_cnt <= w_pre_cnt;
            r_tdi <= 1'b0;
          end
        end
        S_PREAMBLE: if (w_pulse_end) begin
          if (!w_last) begin
            r_cnt <= r_cnt - 7'd1;
            r_tms <= r_pre[0];
            r_pre <= {1'b0, r_pre[5:1]};
          end else if (w_is_scan) begin
            r_cnt <= w_shift_len;
            r_tms <= (w_shift_len == 7'd1);
            r_tdi <= r_sh[0];
          end else begin
            r_rsp_err <= 1'b0;
            if (r_op == c_op_tap_reset) r_tap_known <= 1'b1;
          end
        end
        S_SHIFT: if (w_pulse_end) begin
          // Last shift bit leaves via Exit1; postamble walks Update then RTI
          r_cnt <= w_last ? 7'd2 : r_cnt - 7'd1;
          r_tms <= w_last ? 1'b1 : (r_cnt == 7'd2);
          r_tdi <= w_last ? 1'b0 : r_sh[1];
          r_sh  <= r_sh >> 1;
        end
        S_POSTAMBLE: if (w_pulse_end) begin
          r_cnt <= r_cnt - 7'd1;
          r_tms <= 1'b0;
          if (w_last) r_rsp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tck     = r_tck;
  assign tms     = r_tms;
  assign tdi     = r_tdi;
  assign rsp_err = r_rsp_err;

`ifdef JTAG_SCAN_SEQUENCER_CAPTURE_EN
  logic [MAX_DR_LEN-1:0] r_cap;
  logic [MAX_DR_LEN-1:0] r_rsp_data;
  logic [6:0]            w_align;

  assign w_align = 7'(MAX_DR_LEN) - w_shift_len;

  // TDO enters at the MSB and is right-justified when the scan completes
  always_ff @(posedge clk or posedge trst_) begin
    if (trst_) begin
      r_cap      <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) r_cap <= '0;
      if ((r_state == S_SHIFT) && (r_div == c_samp_at)) r_cap <= {tdo, r_cap[MAX_DR_LEN-1:1]};
      if (w_accept && w_no_pulse) r_rsp_data <= '0;
      if ((r_state == S_PREAMBLE) && w_pulse_end && w_last && !w_is_scan) r_rsp_data <= '0;
      if ((r_state == S_POSTAMBLE) && w_pulse_end && w_last) r_rsp_data <= r_cap >> w_align;
    end
  end

  assign rsp_data = r_rsp_data;
`else
  logic w_unused_tdo;
  assign w_unused_tdo = tdo;
  assign rsp_data     = '0;
`endif

endmodule
`default_nettype wire
